// File: rtl/btb_2bit_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Defining BPRED_PERF_CNT_EN adds saturating update and mispredict counters on two extra ports.
module btb_2bit_predictor #(
   parameter  int unsigned NENTRIES = 16,
   localparam int unsigned IDX_BITS = $clog2(NENTRIES)
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] current_PC,
   output logic        predict_taken,
   output logic [31:0] target_addr,
   input  logic        update_predictor,
   input  logic [31:0] update_addr,
   input  logic        branch_result,
   input  logic        prediction,
   input  logic [31:0] update_target
`ifdef BPRED_PERF_CNT_EN
   ,
   output logic [31:0] update_count,
   output logic [31:0] mispredict_count
`endif
);

   localparam int unsigned TAG_BITS = 30 - IDX_BITS;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_t;

   logic                valid  [NENTRIES];
   logic [TAG_BITS-1:0] tag    [NENTRIES];
   logic [31:0]         target [NENTRIES];
   ctr_t                ctr    [NENTRIES];

   logic [IDX_BITS-1:0] idx;
   logic [IDX_BITS-1:0] uidx;
   logic [TAG_BITS-1:0] ptag;
   logic [TAG_BITS-1:0] utag;
   logic                hit;
   logic                uhit;
   logic                unused_bits;

   function automatic ctr_t sat_inc(input ctr_t c);
      return (c == STRONG_T) ? STRONG_T : ctr_t'(c + 2'd1);
   endfunction

   function automatic ctr_t sat_dec(input ctr_t c);
      return (c == STRONG_NT) ? STRONG_NT : ctr_t'(c - 2'd1);
   endfunction

   assign idx  = current_PC[IDX_BITS+1:2];
   assign ptag = current_PC[31:IDX_BITS+2];
   assign uidx = update_addr[IDX_BITS+1:2];
   assign utag = update_addr[31:IDX_BITS+2];

   // Lookup reads only registered state, so a same-cycle update is seen one cycle later.
   always_comb begin
      hit           = valid[idx] && (tag[idx] == ptag);
      predict_taken = hit && ctr[idx][1];
      target_addr   = predict_taken ? target[idx] : current_PC + 32'd4;
   end

   assign uhit = valid[uidx] && (tag[uidx] == utag);

   // Tag and target carry no reset; valid gates every use of them.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int unsigned i = 0; i < NENTRIES; i++) begin
            valid[i] <= 1'b0;
            ctr[i]   <= WEAK_NT;
         end
      end else if (update_predictor) begin
         if (uhit) begin
            if (branch_result) begin
               ctr[uidx]    <= sat_inc(ctr[uidx]);
               target[uidx] <= update_target;
            end else begin
               ctr[uidx]    <= sat_dec(ctr[uidx]);
            end
         end else if (branch_result) begin
            valid[uidx]  <= 1'b1;
            tag[uidx]    <= utag;
            target[uidx] <= update_target;
            ctr[uidx]    <= WEAK_T;
         end
      end
   end

`ifdef BPRED_PERF_CNT_EN
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         update_count     <= '0;
         mispredict_count <= '0;
      end else if (update_predictor) begin
         if (update_count != '1) begin
            update_count <= update_count + 32'd1;
         end
         if ((prediction != branch_result) && (mispredict_count != '1)) begin
            mispredict_count <= mispredict_count + 32'd1;
         end
      end
   end

   assign unused_bits = ^{current_PC[1:0], update_addr[1:0]};
`else
   assign unused_bits = ^{current_PC[1:0], update_addr[1:0], prediction};
`endif

endmodule

// File: tb/tb_btb_2bit_predictor.sv
// Directed bench for btb_2bit_predictor: per-cycle comparison against a word-address BTB model
// plus literal expectations at key points of the sequence.
module tb_btb_2bit_predictor;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] current_PC;
   logic        predict_taken;
   logic [31:0] target_addr;
   logic        update_predictor;
   logic [31:0] update_addr;
   logic        branch_result;
   logic        prediction;
   logic [31:0] update_target;
`ifdef BPRED_PERF_CNT_EN
   logic [31:0] update_count;
   logic [31:0] mispredict_count;
`endif

   int checks   = 0;
   int failures = 0;

   btb_2bit_predictor #(.NENTRIES(16)) dut (
      .CLK              (CLK),
      .nRST             (nRST),
      .current_PC       (current_PC),
      .predict_taken    (predict_taken),
      .target_addr      (target_addr),
      .update_predictor (update_predictor),
      .update_addr      (update_addr),
      .branch_result    (branch_result),
      .prediction       (prediction),
      .update_target    (update_target)
`ifdef BPRED_PERF_CNT_EN
      ,
      .update_count     (update_count),
      .mispredict_count (mispredict_count)
`endif
   );

   always #5 CLK = ~CLK;

   // Model: each slot remembers the full word address of the branch it holds.
   bit          m_valid [16];
   bit   [29:0] m_word  [16];
   bit   [31:0] m_tgt   [16];
   int          m_ctr   [16];
   bit          model_ok = 1'b0;
   longint      m_upd = 0;
   longint      m_mis = 0;
   bit   [29:0] mw;
   int          mi;

   always @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
         end
         m_upd    = 0;
         m_mis    = 0;
         model_ok = 1'b1;
      end else if (update_predictor) begin
         mw = update_addr[31:2];
         mi = int'(mw % 30'd16);
         if (m_valid[mi] && m_word[mi] == mw) begin
            if (branch_result) begin
               m_ctr[mi] = (m_ctr[mi] >= 3) ? 3 : m_ctr[mi] + 1;
               m_tgt[mi] = update_target;
            end else begin
               m_ctr[mi] = (m_ctr[mi] <= 0) ? 0 : m_ctr[mi] - 1;
            end
         end else if (branch_result) begin
            m_valid[mi] = 1'b1;
            m_word[mi]  = mw;
            m_tgt[mi]   = update_target;
            m_ctr[mi]   = 2;
         end
         if (m_upd < 64'hFFFF_FFFF) m_upd++;
         if (prediction != branch_result && m_mis < 64'hFFFF_FFFF) m_mis++;
      end
   end

   function automatic void model_lookup(input logic [31:0] pc, output logic t,
                                        output logic [31:0] a);
      bit [29:0] w;
      int        i;
      w = pc[31:2];
      i = int'(w % 30'd16);
      t = m_valid[i] && (m_word[i] == w) && (m_ctr[i] >= 2);
      a = t ? m_tgt[i] : pc + 32'd4;
   endfunction

   logic        exp_t;
   logic [31:0] exp_a;

   always @(negedge CLK) begin
      if (model_ok) begin
         model_lookup(current_PC, exp_t, exp_a);
         checks++;
         if (predict_taken !== exp_t) begin
            failures++;
            $display("FAIL cyc_taken pc=%h got=%b exp=%b t=%0t", current_PC, predict_taken, exp_t, $time);
         end
         checks++;
         if (target_addr !== exp_a) begin
            failures++;
            $display("FAIL cyc_target pc=%h got=%h exp=%h t=%0t", current_PC, target_addr, exp_a, $time);
         end
`ifdef BPRED_PERF_CNT_EN
         checks++;
         if (update_count !== 32'(m_upd)) begin
            failures++;
            $display("FAIL cyc_upd_cnt got=%0d exp=%0d t=%0t", update_count, m_upd, $time);
         end
         checks++;
         if (mispredict_count !== 32'(m_mis)) begin
            failures++;
            $display("FAIL cyc_mis_cnt got=%0d exp=%0d t=%0t", mispredict_count, m_mis, $time);
         end
`endif
      end
   end

   task automatic drive(input logic [31:0] pc, input logic upd, input logic [31:0] ua,
                        input logic res, input logic pred, input logic [31:0] ut);
      @(posedge CLK);
      #1;
      current_PC       = pc;
      update_predictor = upd;
      update_addr      = ua;
      branch_result    = res;
      prediction       = pred;
      update_target    = ut;
   endtask

   // Idle cycle with junk on the ignored update fields.
   task automatic idle(input logic [31:0] pc);
      drive(pc, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 32'hDEAD_BEE0);
   endtask

   task automatic upd(input logic [31:0] ua, input logic res, input logic pred,
                      input logic [31:0] ut);
      drive(ua, 1'b1, ua, res, pred, ut);
   endtask

   task automatic lit(input string name, input logic t, input logic [31:0] a);
      #2;
      checks++;
      if (predict_taken !== t) begin
         failures++;
         $display("FAIL %s taken got=%b exp=%b", name, predict_taken, t);
      end
      checks++;
      if (target_addr !== a) begin
         failures++;
         $display("FAIL %s target got=%h exp=%h", name, target_addr, a);
      end
   endtask

   task automatic reset_with_update();
      drive(32'h0000_0104, 1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0999);
      nRST = 1'b0;
      @(posedge CLK);
      #1;
      nRST             = 1'b1;
      update_predictor = 1'b0;
   endtask

`ifdef BPRED_PERF_CNT_EN
   task automatic lit_cnt(input string name, input logic [31:0] u, input logic [31:0] m);
      #2;
      checks++;
      if (update_count !== u) begin
         failures++;
         $display("FAIL %s update_count got=%0d exp=%0d", name, update_count, u);
      end
      checks++;
      if (mispredict_count !== m) begin
         failures++;
         $display("FAIL %s mispredict_count got=%0d exp=%0d", name, mispredict_count, m);
      end
   endtask
`endif

   initial begin
      nRST             = 1'b0;
      current_PC       = 32'h0000_0100;
      update_predictor = 1'b1;
      update_addr      = 32'h0000_0100;
      branch_result    = 1'b1;
      prediction       = 1'b1;
      update_target    = 32'h0000_0200;
      repeat (2) @(posedge CLK);
      #1;
      nRST             = 1'b1;
      update_predictor = 1'b0;
      lit("reset_lookup", 1'b0, 32'h0000_0104);

      upd(32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200);
      lit("same_cycle_old", 1'b0, 32'h0000_0104);
      idle(32'h0000_0100);
      lit("alloc_wt", 1'b1, 32'h0000_0200);

      repeat (3) upd(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200);
      upd(32'h0000_0100, 1'b0, 1'b1, 32'h0000_0999);
      idle(32'h0000_0100);
      lit("nt1_from_st", 1'b1, 32'h0000_0200);
      upd(32'h0000_0100, 1'b0, 1'b1, 32'h0000_0999);
      idle(32'h0000_0100);
      lit("nt2_wnt", 1'b0, 32'h0000_0104);
      repeat (2) upd(32'h0000_0100, 1'b0, 1'b0, 32'h0000_0999);
      upd(32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200);
      idle(32'h0000_0100);
      lit("sat_low", 1'b0, 32'h0000_0104);
      upd(32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200);
      idle(32'h0000_0100);
      lit("recover", 1'b1, 32'h0000_0200);

      upd(32'h0000_0140, 1'b1, 1'b0, 32'h0000_0300);
      idle(32'h0000_0100);
      lit("alias_evict", 1'b0, 32'h0000_0104);
      idle(32'h0000_0140);
      lit("alias_new", 1'b1, 32'h0000_0300);

      upd(32'h0000_0500, 1'b0, 1'b0, 32'h0000_0600);
      idle(32'h0000_0500);
      lit("nt_miss", 1'b0, 32'h0000_0504);
      repeat (3) drive(32'h0000_0140, 1'b0, 32'h0000_0140, 1'b0, 1'b1, 32'h0000_0777);
      lit("no_update", 1'b1, 32'h0000_0300);

      upd(32'h0000_0104, 1'b1, 1'b0, 32'h0000_0444);
      idle(32'h0000_0104);
      lit("idx1", 1'b1, 32'h0000_0444);
      idle(32'h0000_0143);
      lit("low_bits", 1'b1, 32'h0000_0300);
      idle(32'hFFFF_FFFC);
      lit("wrap", 1'b0, 32'h0000_0000);
      upd(32'h0000_0140, 1'b1, 1'b1, 32'h0000_0380);
      idle(32'h0000_0140);
      lit("hit_retarget", 1'b1, 32'h0000_0380);

      reset_with_update();
      current_PC = 32'h0000_0140;
      lit("mid_reset", 1'b0, 32'h0000_0144);
      upd(32'h0000_0180, 1'b1, 1'b1, 32'h0000_0A00);
      upd(32'h0000_0180, 1'b1, 1'b0, 32'h0000_0A00);
      upd(32'h0000_0184, 1'b0, 1'b1, 32'h0000_0B00);
      upd(32'h0000_0184, 1'b0, 1'b0, 32'h0000_0B00);
      upd(32'h0000_0180, 1'b1, 1'b1, 32'h0000_0A00);
      idle(32'h0000_0180);
      lit("perf_entry", 1'b1, 32'h0000_0A00);
`ifdef BPRED_PERF_CNT_EN
      lit_cnt("perf_counts", 32'd5, 32'd2);
`endif
      reset_with_update();
      current_PC = 32'h0000_0180;
      lit("reset_clears", 1'b0, 32'h0000_0184);
`ifdef BPRED_PERF_CNT_EN
      lit_cnt("reset_counts", 32'd0, 32'd0);
`endif
      idle(32'h0000_0104);
      lit("reset_drop_upd", 1'b0, 32'h0000_0108);
      repeat (2) idle(32'h0000_0100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/btb_2bit_predictor.md
Name: btb_2bit_predictor

Overview:
- Predictor-side endpoint of the branch predictor/pipeline interface.
- Direct-mapped branch target buffer (BTB); each entry holds a 2-bit saturating direction counter.
- Fetch presents the PC and gets a same-cycle taken prediction and next-fetch target.
- Execute/resolve writes back the branch outcome, the original prediction and the resolved target; state updates on the next clock edge.

Parameters:
- NENTRIES, 16, number of BTB entries; power of two, minimum 2.
- IDX_BITS, $clog2(NENTRIES), index width; derived, not overridden.

Ports:
- CLK  input  1  single clock, rising-edge.
- nRST  input  1  reset, synchronous, active-low.
- current_PC  input  32  fetch PC to predict.
- predict_taken  output  1  1 = predicted taken.
- target_addr  output  32  predicted next fetch address.
- update_predictor  input  1  1-cycle strobe: a resolved branch is presented.
- update_addr  input  32  PC of the resolved branch.
- branch_result  input  1  actual outcome, 1 = taken.
- prediction  input  1  prediction issued for that branch earlier.
- update_target  input  32  resolved taken target of that branch.

Behaviour:
- Storage per entry: valid (1), tag (30-IDX_BITS), target (32), ctr (2).
- Index = PC[IDX_BITS+1:2]; tag = PC[31:IDX_BITS+2]. PC[1:0] ignored.
- Lookup is purely combinational from current_PC and registered state, with zero latency.
  - hit = valid[idx] && tag[idx] == tag(current_PC).
  - predict_taken = hit && ctr[idx][1].
  - target_addr = entry target when predict_taken; otherwise current_PC + 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Update happens on the rising edge where update_predictor = 1 (uidx/utag from update_addr).
  - Hit, taken: ctr saturating increment (11 stays 11); target <= update_target.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate, overwriting any valid entry with another tag. valid<=1, tag<=utag, target<=update_target, ctr<=10.
  - Miss, not taken: no state change, no allocation.
- update_predictor = 0: no state change; branch_result, prediction and update_target are ignored.
- Same-cycle lookup and update on the same index: lookup returns pre-update state, with no bypass. The new state is visible from the next cycle.
- Reset (nRST = 0 at a rising edge):
  - All valid <= 0 and ctr <= 01; tag and target are don't-care.
  - An update presented in the same cycle as reset is dropped; reset dominates.
- Output values: the outputs are combinational, so after reset predict_taken = 0 and target_addr = current_PC + 4.
- Reset asserted mid-operation clears all state at that edge; no partial entries survive.
- prediction input is used only by the optional feature; in the base design it is ignored.

Optional Feature:
- Macro: BPRED_PERF_CNT_EN.
- With the macro defined, two extra ports are added:
  - update_count (output, 32): counts update_predictor pulses.
  - mispredict_count (output, 32): counts updates where prediction != branch_result.
- Counter rules:
  - Both counters are registered and reset to 0 on nRST.
  - Both saturate at 0xFFFFFFFF.
  - Each is incremented at the same edge as the BTB update.
- Without the macro: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then current_PC = 0x00000100 -> predict_taken = 0, target_addr = 0x00000104.
- Taken update: addr 0x100, result 1, target 0x200. Next cycle, current_PC = 0x100 -> predict_taken = 1, target_addr = 0x200 (ctr = 10).
- Counter saturation on entry 0x100:
  - Two further taken updates -> ctr = 11.
  - Then three not-taken updates -> ctr 10, 01, 00; predict_taken = 0 after the second.
  - A fourth not-taken update keeps ctr = 00.
- Alias eviction with NENTRIES = 16:
  - Allocate 0x100 -> 0x200, then taken update 0x140 -> 0x300 (same index, different tag).
  - Result: lookup 0x100 misses (predict_taken = 0, target 0x104); lookup 0x140 returns 0x300.
- Not-taken miss: update 0x500, result 0 -> lookup 0x500 still misses. Same-cycle lookup/update of 0x100 returns old state; the new state appears the next cycle.
- BPRED_PERF_CNT_EN:
  - 5 updates with 2 mismatched predictions -> update_count = 5, mispredict_count = 2.
  - nRST low for one edge -> both counters 0 and all entries invalid.
